market_feed_parser: RTL and testbench
=====================================

# market_feed_parser

Parametrised successor to the fixed BTC/ETH network front end. It parses multi-symbol market-data packets from the 10GbE PHY beat stream into a NUM_SYMBOLS-entry price table. Prices are staged and committed atomically only for well-formed packets, and drop, sequence-gap and latency statistics are kept. An order-TX queue formats core trade requests into single-beat frames under ready/valid backpressure.

## Interface
- NUM_SYMBOLS, 4: price table entries (2..16)
- RX_MAGIC, 16'hC0DE: required header magic
- TX_MAGIC, 16'hDEAD: order frame tag
- ORDER_FIFO_DEPTH, 4: order queue depth (power of 2, ≥2)
- clk_156mhz  in  1  sole clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  64  PHY beat
- rx_valid  in  1  beat valid; no backpressure
- rx_last  in  1  final beat of packet
- price_table  out  64*NUM_SYMBOLS  entry i at [64i+63:64i]
- price_update  out  NUM_SYMBOLS  one-cycle mask of entries written by a commit
- order_valid / order_ready  in / out  1  core order handshake
- order_symbol  in  8  symbol index
- order_side  in  1  1 = buy
- order_price  in  64  price
- tx_data  out  64  order frame
- tx_valid / tx_ready  out / in  1  TX handshake
- total_packets, dropped_packets, seq_gaps, network_latency  out  32 each

## Operation
- Header beat: [63:48] magic, [47:40] K = symbol count, [31:0] seq. Body beat: [63:56] symbol index, [47:0] price; entry value is {price, 16'h0}.
- FSM states:
  - IDLE: a valid beat is a header, total_packets++, latency_counter=1. Go to BODY if magic==RX_MAGIC, 1≤K≤NUM_SYMBOLS and !rx_last; otherwise go to DROP, or to IDLE with dropped_packets++ if rx_last.
  - BODY: latency_counter++ every cycle. A valid beat writes the shadow entry and sets shadow mask bit; a duplicate symbol means the later beat wins. Beat count == K with rx_last goes to COMMIT.
  - BODY drop conditions, each dropped_packets++: index ≥ NUM_SYMBOLS; rx_last before K beats; beat K without rx_last. The drop is to IDLE if rx_last was seen, otherwise to DROP.
  - COMMIT: shadow → price_table for masked entries, price_update=mask, network_latency=latency_counter+1, seq check. A valid beat in COMMIT is handled exactly as in IDLE, so back-to-back packets are supported.
  - DROP: discard beats until the rx_last beat, then go to IDLE. Dropped packets never alter the price table, the seq state or network_latency.
- Sequence check:
  - After a commit, expected = seq+1.
  - A committed seq ≠ expected increments seq_gaps. The first commit after reset is never a gap.
  - Gapped packets are still committed.
- Order path:
  - Push on order_valid&&order_ready; order_ready = !full, independent of pop.
  - tx_valid = !empty; pop on tx_valid&&tx_ready.
  - Frame = {TX_MAGIC, order_side, 7'b0, order_symbol, order_price[63:32]}.
- Counters wrap mod 2^32.

## Timing
- Reset, asynchronous, all outputs 0:
  - price_table and price_update
  - counters
  - order_ready=0 during reset, 1 from the first cycle after release
  - tx_valid=0, FIFO empty
  - FSM to IDLE, seq-check unarmed, shadow mask cleared
- Reset mid-packet abandons the packet with no commit.
- Contiguous K-beat packet: header sampled at edge E0, last body at EK, commit at EK+1.
  - price_table, price_update and network_latency=K+2 are visible after EK+1.
  - price_update is high for exactly one cycle.
- rx_valid gaps stall the parse but still count toward latency.
- Order timing:
  - An order accepted at edge E drives tx_valid after E.
  - tx_data is held stable while tx_valid&&!tx_ready.
  - Simultaneous push and pop at non-full, non-empty keeps occupancy constant.
  - At full, order_ready is low even when a pop occurs that cycle.

## Structure
- Package hft_net_pkg:
  - parser state enum (IDLE, BODY, COMMIT, DROP)
  - header/body field bit offsets
  - price scaling shift (16)
  - default RX_MAGIC/TX_MAGIC constants
- Sub-module order_tx_fifo: parametrised depth, synchronous circular buffer with pointer+1 wrap bit, full/empty flags.
- Everything else is in market_feed_parser.

## Test plan
- Header {C0DE, K=2, seq=5}, bodies {idx1, 48'h100}, {idx3, 48'h200, last}, contiguous → entry1=64'h0100_0000 (48'h100 shifted left 16), entry3=64'h0200_0000, price_update=4'b1010 for 1 cycle, network_latency=4, total_packets=1.
- Header magic 16'hBEEF, 3 beats → dropped_packets=1, price_table unchanged, no price_update pulse.
- K=3 with rx_last on body beat 2 → dropped, staged values not committed; next valid packet commits only its own entries.
- Commits with seq 5, then 6, then 9 → seq_gaps=1; the seq-9 packet is still committed.
- Second header arriving on the COMMIT cycle of the first → both commit, total_packets=2, no drop.
- tx_ready=0, push 5 orders → order_ready low after 4 accepts. Raise tx_ready → 4 frames in order, first = {16'hDEAD, side, 7'b0, symbol, price[63:32]}, stable while stalled.

Source files
------------

// File: rtl/hft_net_pkg.sv
// Shared definitions for the market-data front end: parser states, beat field
// offsets, price scaling and default frame magics.
package hft_net_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BODY   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DROP   = 2'd3
    } parser_state_e;

    localparam int HDR_MAGIC_MSB  = 63;
    localparam int HDR_MAGIC_LSB  = 48;
    localparam int HDR_K_MSB      = 47;
    localparam int HDR_K_LSB      = 40;
    localparam int HDR_SEQ_MSB    = 31;
    localparam int HDR_SEQ_LSB    = 0;
    localparam int BODY_IDX_MSB   = 63;
    localparam int BODY_IDX_LSB   = 56;
    localparam int BODY_PRICE_MSB = 47;
    localparam int BODY_PRICE_LSB = 0;

    localparam int PRICE_SHIFT = 16;

    localparam logic [15:0] DEFAULT_RX_MAGIC = 16'hC0DE;
    localparam logic [15:0] DEFAULT_TX_MAGIC = 16'hDEAD;

    // Wire prices carry 48 bits; the table stores them in 64-bit fixed point.
    function automatic logic [63:0] scale_price(input logic [47:0] price);
        return {price, {PRICE_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/order_tx_fifo.sv
// Circular-buffer FIFO for formatted order frames; pointers carry an extra
// wrap bit so full and empty are distinguished without a counter.
module order_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk_156mhz,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_156mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers define which
    // entries are meaningful, and resetting an array costs a mux per bit.
    always_ff @(posedge clk_156mhz) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/market_feed_parser.sv
// Multi-symbol market-data parser with atomic price-table commits, drop/gap/
// latency statistics, and an order-TX queue under ready/valid backpressure.
module market_feed_parser
    import hft_net_pkg::*;
#(
    parameter int          NUM_SYMBOLS      = 4,
    parameter logic [15:0] RX_MAGIC         = DEFAULT_RX_MAGIC,
    parameter logic [15:0] TX_MAGIC         = DEFAULT_TX_MAGIC,
    parameter int          ORDER_FIFO_DEPTH = 4
) (
    input  logic                      clk_156mhz,
    input  logic                      rst_n,
    input  logic [63:0]               rx_data,
    input  logic                      rx_valid,
    input  logic                      rx_last,
    output logic [64*NUM_SYMBOLS-1:0] price_table,
    output logic [NUM_SYMBOLS-1:0]    price_update,
    input  logic                      order_valid,
    output logic                      order_ready,
    input  logic [7:0]                order_symbol,
    input  logic                      order_side,
    input  logic [63:0]               order_price,
    output logic [63:0]               tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [31:0]               total_packets,
    output logic [31:0]               dropped_packets,
    output logic [31:0]               seq_gaps,
    output logic [31:0]               network_latency
);
    localparam int         SYM_W     = $clog2(NUM_SYMBOLS);
    localparam logic [7:0] NUM_SYM_B = 8'(NUM_SYMBOLS);

    parser_state_e state, state_next;

    logic [7:0]             k_q;
    logic [7:0]             beat_cnt_q;
    logic [31:0]            seq_q;
    logic [31:0]            expected_seq_q;
    logic                   seq_armed_q;
    logic [31:0]            latency_q;
    logic [NUM_SYMBOLS-1:0] shadow_mask_q;
    logic [63:0]            shadow_q [NUM_SYMBOLS];
    logic [63:0]            price_q  [NUM_SYMBOLS];

    logic [15:0] hdr_magic;
    logic [7:0]  hdr_k;
    logic [31:0] hdr_seq;
    logic [7:0]  body_idx;
    logic [47:0] body_price;
    logic [7:0]  beat_cnt_inc;
    logic        hdr_good;
    logic        idx_bad;

    logic hdr_take;
    logic body_wr;
    logic drop_pkt;
    logic do_commit;

    assign hdr_magic    = rx_data[HDR_MAGIC_MSB:HDR_MAGIC_LSB];
    assign hdr_k        = rx_data[HDR_K_MSB:HDR_K_LSB];
    assign hdr_seq      = rx_data[HDR_SEQ_MSB:HDR_SEQ_LSB];
    assign body_idx     = rx_data[BODY_IDX_MSB:BODY_IDX_LSB];
    assign body_price   = rx_data[BODY_PRICE_MSB:BODY_PRICE_LSB];
    assign beat_cnt_inc = beat_cnt_q + 8'd1;
    assign hdr_good     = (hdr_magic == RX_MAGIC) && (hdr_k != 8'd0) && (hdr_k <= NUM_SYM_B);
    assign idx_bad      = (body_idx >= NUM_SYM_B);

    always_ff @(posedge clk_156mhz or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block is defaulted first so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        hdr_take   = 1'b0;
        body_wr    = 1'b0;
        drop_pkt   = 1'b0;
        do_commit  = (state == ST_COMMIT);
        case (state)
            // COMMIT accepts a new header exactly like IDLE for back-to-back packets.
            ST_IDLE, ST_COMMIT: begin
                state_next = ST_IDLE;
                if (rx_valid) begin
                    hdr_take = 1'b1;
                    if (hdr_good && !rx_last) begin
                        state_next = ST_BODY;
                    end else begin
                        drop_pkt   = 1'b1;
                        state_next = rx_last ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_BODY: begin
                if (rx_valid) begin
                    if (idx_bad) begin
                        drop_pkt   = 1'b1;
                        state_next = rx_last ? ST_IDLE : ST_DROP;
                    end else begin
                        body_wr = 1'b1;
                        if (beat_cnt_inc == k_q) begin
                            if (rx_last) begin
                                state_next = ST_COMMIT;
                            end else begin
                                drop_pkt   = 1'b1;
                                state_next = ST_DROP;
                            end
                        end else if (rx_last) begin
                            drop_pkt   = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (rx_valid && rx_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_156mhz or negedge rst_n) begin
        if (!rst_n) begin
            k_q             <= '0;
            beat_cnt_q      <= '0;
            seq_q           <= '0;
            expected_seq_q  <= '0;
            seq_armed_q     <= 1'b0;
            latency_q       <= '0;
            shadow_mask_q   <= '0;
            price_update    <= '0;
            total_packets   <= '0;
            dropped_packets <= '0;
            seq_gaps        <= '0;
            network_latency <= '0;
            for (int i = 0; i < NUM_SYMBOLS; i++) price_q[i] <= '0;
        end else begin
            price_update <= '0;
            if (do_commit) begin
                for (int i = 0; i < NUM_SYMBOLS; i++) begin
                    if (shadow_mask_q[i]) price_q[i] <= shadow_q[i];
                end
                price_update    <= shadow_mask_q;
                network_latency <= latency_q + 32'd1;
                if (seq_armed_q && (seq_q != expected_seq_q)) seq_gaps <= seq_gaps + 32'd1;
                expected_seq_q  <= seq_q + 32'd1;
                seq_armed_q     <= 1'b1;
            end
            if (state == ST_BODY) latency_q <= latency_q + 32'd1;
            if (hdr_take) begin
                total_packets <= total_packets + 32'd1;
                latency_q     <= 32'd1;
                shadow_mask_q <= '0;
                beat_cnt_q    <= '0;
                k_q           <= hdr_k;
                seq_q         <= hdr_seq;
            end
            if (body_wr) begin
                shadow_mask_q[body_idx[SYM_W-1:0]] <= 1'b1;
                beat_cnt_q                         <= beat_cnt_inc;
            end
            if (drop_pkt) dropped_packets <= dropped_packets + 32'd1;
        end
    end

    // Entries outside shadow_mask_q are never committed, so stale data is harmless.
    always_ff @(posedge clk_156mhz) begin
        if (body_wr) shadow_q[body_idx[SYM_W-1:0]] <= scale_price(body_price);
    end

    for (genvar g = 0; g < NUM_SYMBOLS; g++) begin : g_table
        assign price_table[64*g +: 64] = price_q[g];
    end

    logic        ready_en_q;
    logic        fifo_full;
    logic        fifo_empty;
    logic [63:0] order_frame;
    logic        unused_price_low;

    // Holds order_ready low while in reset and for the release cycle itself.
    always_ff @(posedge clk_156mhz or negedge rst_n) begin
        if (!rst_n) ready_en_q <= 1'b0;
        else        ready_en_q <= 1'b1;
    end

    assign order_ready      = ready_en_q && !fifo_full;
    assign tx_valid         = !fifo_empty;
    assign order_frame      = {TX_MAGIC, order_side, 7'b0, order_symbol, order_price[63:32]};
    assign unused_price_low = ^order_price[31:0];

    order_tx_fifo #(
        .DEPTH (ORDER_FIFO_DEPTH),
        .WIDTH (64)
    ) u_order_tx_fifo (
        .clk_156mhz (clk_156mhz),
        .rst_n      (rst_n),
        .push       (order_valid && order_ready),
        .push_data  (order_frame),
        .pop        (tx_valid && tx_ready),
        .pop_data   (tx_data),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

endmodule

// File: tb/tb_market_feed_parser.sv
// Directed bench for market_feed_parser with a commit scoreboard and an order
// frame queue; every expectation is derived from the stimulus.
module tb_market_feed_parser;

    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0]       mask;
        logic [N-1:0][63:0] val;
        logic [31:0]        lat;
        logic [31:0]        cyc;
    } commit_t;

    logic              clk_156mhz = 1'b0;
    logic              rst_n;
    logic [63:0]       rx_data;
    logic              rx_valid;
    logic              rx_last;
    logic [64*N-1:0]   price_table;
    logic [N-1:0]      price_update;
    logic              order_valid;
    logic              order_ready;
    logic [7:0]        order_symbol;
    logic              order_side;
    logic [63:0]       order_price;
    logic [63:0]       tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [31:0]       total_packets;
    logic [31:0]       dropped_packets;
    logic [31:0]       seq_gaps;
    logic [31:0]       network_latency;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    commit_t     exp_q[$];
    commit_t     mon_e;
    logic [63:0] tx_q[$];
    logic [63:0] model [N];
    logic [7:0]  pk_idx [N];
    logic [47:0] pk_prc [N];

    market_feed_parser #(
        .NUM_SYMBOLS      (N),
        .RX_MAGIC         (16'hC0DE),
        .TX_MAGIC         (16'hDEAD),
        .ORDER_FIFO_DEPTH (4)
    ) dut (
        .clk_156mhz      (clk_156mhz),
        .rst_n           (rst_n),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_last         (rx_last),
        .price_table     (price_table),
        .price_update    (price_update),
        .order_valid     (order_valid),
        .order_ready     (order_ready),
        .order_symbol    (order_symbol),
        .order_side      (order_side),
        .order_price     (order_price),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .total_packets   (total_packets),
        .dropped_packets (dropped_packets),
        .seq_gaps        (seq_gaps),
        .network_latency (network_latency)
    );

    always #5 clk_156mhz = ~clk_156mhz;
    always @(posedge clk_156mhz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every price_update pulse must match the oldest expected commit.
    always @(negedge clk_156mhz) begin
        if (rst_n && price_update != '0) begin
            if (exp_q.size() == 0) begin
                check("commit_unexpected", 64'(price_update), 64'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("commit_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("commit_mask", 64'(price_update), 64'(mon_e.mask));
                check("commit_latency", 64'(network_latency), 64'(mon_e.lat));
                for (int i = 0; i < N; i++) if (mon_e.mask[i]) model[i] = mon_e.val[i];
                for (int i = 0; i < N; i++) check("commit_entry", price_table[64*i +: 64], model[i]);
            end
        end
    end

    task automatic idle_cycle();
        @(posedge clk_156mhz);
        #1;
    endtask

    task automatic beat(input logic [63:0] d, input logic last);
        rx_data  = d;
        rx_valid = 1'b1;
        rx_last  = last;
        idle_cycle();
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_data  = '0;
    endtask

    // Sends a well-formed packet from pk_idx/pk_prc and queues its expected commit.
    task automatic send_good(input logic [31:0] seq, input int k, input int gap);
        commit_t e;
        e = '0;
        beat({16'hC0DE, 8'(k), 8'h00, seq}, 1'b0);
        for (int i = 0; i < k; i++) begin
            if (i == 1) repeat (gap) idle_cycle();
            beat({pk_idx[i], 8'h00, pk_prc[i]}, (i == k - 1));
            e.mask[pk_idx[i][1:0]] = 1'b1;
            e.val[pk_idx[i][1:0]]  = {pk_prc[i], 16'h0000};
        end
        e.lat = 32'(k + 2 + gap);
        e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < N; i++) check(tag, price_table[64*i +: 64], model[i]);
    endtask

    task automatic check_stats(input logic [31:0] tot, input logic [31:0] drp, input logic [31:0] gap);
        check("total_packets", 64'(total_packets), 64'(tot));
        check("dropped_packets", 64'(dropped_packets), 64'(drp));
        check("seq_gaps", 64'(seq_gaps), 64'(gap));
        check("commits_pending", 64'(exp_q.size()), 64'h0);
    endtask

    function automatic logic [63:0] frame(input logic side, input logic [7:0] sym, input logic [63:0] p);
        return {16'hDEAD, side, 7'b0, sym, p[63:32]};
    endfunction

    initial begin
        int accepted;
        int frames;
        rst_n        = 1'b0;
        rx_data      = '0;
        rx_valid     = 1'b0;
        rx_last      = 1'b0;
        order_valid  = 1'b0;
        order_symbol = '0;
        order_side   = 1'b0;
        order_price  = '0;
        tx_ready     = 1'b0;
        for (int i = 0; i < N; i++) model[i] = '0;

        // Reset state
        repeat (3) @(posedge clk_156mhz);
        #1;
        check("rst_order_ready", 64'(order_ready), 64'h0);
        check("rst_tx_valid", 64'(tx_valid), 64'h0);
        check("rst_price_update", 64'(price_update), 64'h0);
        check("rst_latency", 64'(network_latency), 64'h0);
        check_table("rst_table");
        check_stats(0, 0, 0);
        @(negedge clk_156mhz);
        rst_n = 1'b1;
        idle_cycle();
        check("order_ready_after_rst", 64'(order_ready), 64'h1);

        // Basic two-entry commit, latency K+2
        pk_idx[0] = 8'd1; pk_prc[0] = 48'h100;
        pk_idx[1] = 8'd3; pk_prc[1] = 48'h200;
        send_good(32'd5, 2, 0);
        repeat (3) idle_cycle();
        check("entry1_value", price_table[64*1 +: 64], 64'h0000_0000_0100_0000);
        check("entry3_value", price_table[64*3 +: 64], 64'h0000_0000_0200_0000);
        check_stats(1, 0, 0);

        // Bad magic, three beats
        beat({16'hBEEF, 8'd1, 8'h00, 32'd0}, 1'b0);
        beat(64'h0100_0000_0000_0777, 1'b0);
        beat(64'h0200_0000_0000_0888, 1'b1);
        repeat (3) idle_cycle();
        check_table("bad_magic_table");
        check_stats(2, 1, 0);

        // K=3 truncated by rx_last on body beat 2
        beat({16'hC0DE, 8'd3, 8'h00, 32'd77}, 1'b0);
        beat({8'd2, 8'h00, 48'hAAA}, 1'b0);
        beat({8'd3, 8'h00, 48'hBBB}, 1'b1);
        repeat (2) idle_cycle();
        check_stats(3, 2, 0);

        // Symbol index out of range
        beat({16'hC0DE, 8'd1, 8'h00, 32'd78}, 1'b0);
        beat({8'd4, 8'h00, 48'hCCC}, 1'b1);
        repeat (2) idle_cycle();
        check_stats(4, 3, 0);

        // Beat K without rx_last, tail discarded
        beat({16'hC0DE, 8'd1, 8'h00, 32'd79}, 1'b0);
        beat({8'd0, 8'h00, 48'hDDD}, 1'b0);
        beat({8'd2, 8'h00, 48'hEEE}, 1'b1);
        repeat (2) idle_cycle();
        check_table("drops_table");
        check_stats(5, 4, 0);

        // seq 6 follows 5: commits only its own entry, no gap
        pk_idx[0] = 8'd0; pk_prc[0] = 48'h600;
        send_good(32'd6, 1, 0);
        repeat (3) idle_cycle();
        check("entry2_untouched", price_table[64*2 +: 64], 64'h0);
        check_stats(6, 4, 0);

        // seq 9 is a gap but still commits; duplicate symbol, later wins; rx_valid gaps
        pk_idx[0] = 8'd0; pk_prc[0] = 48'h900;
        pk_idx[1] = 8'd0; pk_prc[1] = 48'h901;
        send_good(32'd9, 2, 2);
        repeat (3) idle_cycle();
        check("dup_later_wins", price_table[64*0 +: 64], 64'h0000_0000_0901_0000);
        check_stats(7, 4, 1);

        // Back-to-back: second header on the first packet's commit cycle
        pk_idx[0] = 8'd2; pk_prc[0] = 48'hA10;
        send_good(32'd10, 1, 0);
        pk_idx[0] = 8'd1; pk_prc[0] = 48'hB11;
        pk_idx[1] = 8'd3; pk_prc[1] = 48'hB13;
        send_good(32'd11, 2, 0);
        repeat (3) idle_cycle();
        check_stats(9, 4, 1);

        // Order queue: fill with tx stalled
        check("tx_valid_empty", 64'(tx_valid), 64'h0);
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            order_symbol = 8'(i + 1);
            order_side   = i[0];
            order_price  = {32'h1000_0000 + 32'(i), 32'hFFFF_FFFF};
            order_valid  = 1'b1;
            if (order_ready) begin
                tx_q.push_back(frame(order_side, order_symbol, order_price));
                accepted++;
            end
            idle_cycle();
            if (i == 0) check("tx_valid_after_push", 64'(tx_valid), 64'h1);
        end
        check("orders_accepted", 64'(accepted), 64'd4);
        check("order_ready_full", 64'(order_ready), 64'h0);
        check("tx_first_frame", tx_data, tx_q[0]);
        idle_cycle();
        check("tx_stable_stalled", tx_data, tx_q[0]);
        tx_ready = 1'b1;
        #1;
        check("order_ready_full_pop", 64'(order_ready), 64'h0);

        // Drain; the fifth order enters alongside a pop
        frames = 0;
        for (int c = 0; c < 20 && (tx_q.size() != 0 || order_valid); c++) begin
            logic acc;
            acc = order_valid && order_ready;
            if (acc) tx_q.push_back(frame(order_side, order_symbol, order_price));
            if (tx_q.size() == 0) begin
                check("tx_spurious", 64'(tx_valid), 64'h0);
            end else if (tx_valid) begin
                check("tx_frame", tx_data, tx_q.pop_front());
                frames++;
            end
            idle_cycle();
            if (acc) order_valid = 1'b0;
        end
        check("frames_sent", 64'(frames), 64'd5);
        check("tx_valid_drained", 64'(tx_valid), 64'h0);
        check("tx_queue_empty", 64'(tx_q.size()), 64'h0);
        tx_ready = 1'b0;

        // Reset mid-packet abandons it and disarms the sequence check
        beat({16'hC0DE, 8'd2, 8'h00, 32'd50}, 1'b0);
        beat({8'd0, 8'h00, 48'h555}, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) model[i] = '0;
        check_table("midrst_table");
        check_stats(0, 0, 0);
        @(negedge clk_156mhz);
        rst_n = 1'b1;
        idle_cycle();
        pk_idx[0] = 8'd1; pk_prc[0] = 48'h123;
        send_good(32'd100, 1, 0);
        repeat (3) idle_cycle();
        check_table("post_rst_table");
        check_stats(1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
